// File: rtl/addr_pair_pkg.sv
// Shared types for the even/odd address-pair sink: address width, FSM states
// and the error codes reported on err_code.
package addr_pair_pkg;

    localparam int ADDR_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_PARITY,
        ERR_PAIR,
        ERR_SEQ
    } err_code_t;

endpackage

// File: rtl/pair_fifo2.sv
// Two-entry FIFO with synchronous flush; head_data reads as zero while empty
// so the data storage itself needs no reset.
module pair_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok, wr_ptr;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign push_ok = push & (~full | pop_ok);
    assign wr_ptr  = rd_ptr_q ^ count_q[0];

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (flush) begin
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/addr_pair_sink.sv
// Checks the even/odd address-pair stream, accumulates checksum and pair count,
// and forwards {data_b, data_a} through a 2-deep valid/ready buffer.
module addr_pair_sink
    import addr_pair_pkg::*;
#(
    parameter int DW         = 8,
    parameter int SUM_W      = 20,
    parameter int START_PAIR = 512,
    parameter int END_PAIR   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DW-1:0]     data_a,
    input  logic [DW-1:0]     data_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic [10:0]       pair_count,
    output logic [SUM_W-1:0]  checksum,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int IDX_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(START_PAIR);
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(END_PAIR);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  exp_q, exp_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_code_t         code_q, code_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;

    logic              accept, push, pop, flush, fifo_full, fifo_empty;
    logic [IDX_W-1:0]  idx;
    logic [SUM_W-1:0]  pair_sum;
    err_code_t         fault;

    assign idx      = addr_a[ADDR_W-1:1];
    assign pair_sum = SUM_W'(data_a) + SUM_W'(data_b);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        fault = ERR_NONE;
        if (addr_a[0]) begin
            fault = ERR_PARITY;
        end else if (addr_b != {addr_a[ADDR_W-1:1], 1'b1}) begin
            fault = ERR_PAIR;
        end else if (idx != exp_q) begin
            fault = ERR_SEQ;
        end
    end

    // exp_q always holds START_IDX while in IDLE, so a fault-free pair there is
    // exactly the start pair; anything else in IDLE is dropped without error.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        eaddr_d = eaddr_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (start) begin
            state_d = IDLE;
            exp_d   = START_IDX;
            cnt_d   = '0;
            sum_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            eaddr_d = '0;
            flush   = 1'b1;
        end else if (accept && (state_q == IDLE || state_q == RUN)) begin
            if (fault == ERR_NONE) begin
                push  = 1'b1;
                sum_d = sum_q + pair_sum;
                cnt_d = cnt_q + 11'd1;
                exp_d = exp_q + IDX_W'(1);
                if (idx == END_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end else if (state_q == RUN) begin
                state_d = ERROR;
                err_d   = 1'b1;
                code_d  = fault;
                eaddr_d = addr_a;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            exp_q   <= START_IDX;
            cnt_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            eaddr_q <= eaddr_d;
        end
    end

    pair_fifo2 #(
        .W(2*DW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .push_data({data_b, data_a}),
        .pop      (pop),
        .head_data(out_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Terminal states swallow everything so the upstream counter may park on its last pair.
    assign in_ready   = (state_q == DONE || state_q == ERROR) ? 1'b1 : ~fifo_full;
    assign out_valid  = ~fifo_empty;
    assign pair_count = cnt_q;
    assign checksum   = sum_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = code_q;
    assign err_addr   = eaddr_q;

endmodule
